// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register-access sequencer: FSM encoding and
// 16-bit command frame field positions.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RD_WAIT,
    DRIVE,
    WAIT_END
  } state_t;

  localparam int CMD_LEN   = 16;
  localparam int RW_BIT    = 15;
  localparam int ADDR_MSB  = 14;
  localparam int ADDR_LSB  = 8;
  localparam int DATA_MSB  = 7;
  localparam int DATA_LSB  = 0;
  localparam int BIT_CNT_W = 6;

endpackage

// File: rtl/spi_pad_sync.sv
// Two-flop synchronizer for one asynchronous SPI pad, followed by a single
// history flop for rise/fall detection.
module spi_pad_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // RESET_VAL lets a pad that is held high across reset come out of reset
  // without producing a false rise edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RESET_VAL;
      sync <= RESET_VAL;
      prev <= RESET_VAL;
    end else begin
      meta <= pad;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/spi_reg_access_ctrl.sv
// SPI-slave register-access sequencer: decodes a 16-bit command frame, issues
// one register strobe, and shifts read data out on MISO with a delayed pad enable.
module spi_reg_access_ctrl
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1,
  parameter int OE_DELAY   = 27
) (
  input  logic              Clock_108M,
  input  logic              Reset,
  input  logic              SPI_SYNC,
  input  logic              SPI_CLK,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  output logic              SPI_Out_EN,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata
);

  localparam int OE_W = $clog2(OE_DELAY);
  localparam logic [OE_W-1:0] OE_LAST = OE_W'(OE_DELAY - 1);
  localparam logic [OE_W-1:0] LOAD_AT = OE_W'(RD_LATENCY + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT    = BIT_CNT_W'(CMD_LEN - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = '1;

  logic sync_lvl, sync_rise, sync_fall_unused;
  logic clk_lvl_unused, clk_rise, clk_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  // SYNC resets high so a reset in mid-frame ignores the remainder of that frame.
  spi_pad_sync #(.RESET_VAL(1'b1)) u_sync_pad (
    .clock(Clock_108M), .reset(Reset), .pad(SPI_SYNC),
    .level(sync_lvl), .rise(sync_rise), .fall(sync_fall_unused)
  );

  spi_pad_sync #(.RESET_VAL(1'b0)) u_clk_pad (
    .clock(Clock_108M), .reset(Reset), .pad(SPI_CLK),
    .level(clk_lvl_unused), .rise(clk_rise), .fall(clk_fall)
  );

  spi_pad_sync #(.RESET_VAL(1'b0)) u_mosi_pad (
    .clock(Clock_108M), .reset(Reset), .pad(SPI_MOSI),
    .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t state, next_state;

  logic [CMD_LEN-2:0]   cmd_sr;
  logic [CMD_LEN-1:0]   cmd_word;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [OE_W-1:0]      oe_cnt;
  logic [DATA_W-1:0]    rd_sr;

  logic frame_end, shift_en, bit_rise, last_rise, load_rd;

  assign cmd_word = {cmd_sr, mosi_lvl};

  always_ff @(posedge Clock_108M) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    frame_end  = 1'b0;
    shift_en   = 1'b0;
    bit_rise   = 1'b0;
    last_rise  = 1'b0;
    load_rd    = 1'b0;
    case (state)
      IDLE: begin
        if (sync_rise) begin
          next_state = CMD;
          shift_en   = clk_rise;
          bit_rise   = clk_rise;
        end
      end
      CMD: begin
        shift_en = clk_rise;
        bit_rise = clk_rise;
        if (clk_rise && bit_cnt == LAST_BIT) begin
          last_rise  = 1'b1;
          next_state = cmd_word[RW_BIT] ? RD_WAIT : WAIT_END;
        end
      end
      // The OE counter doubles as the read-latency counter; it starts at the
      // 16th rise, so LOAD_AT lands RD_LATENCY cycles after the reg_rd pulse.
      RD_WAIT: begin
        bit_rise = clk_rise;
        if (oe_cnt == LOAD_AT) begin
          load_rd    = 1'b1;
          next_state = DRIVE;
        end
      end
      DRIVE, WAIT_END: bit_rise = clk_rise;
      default: next_state = IDLE;
    endcase
    if (state != IDLE && !sync_lvl) begin
      frame_end  = 1'b1;
      last_rise  = 1'b0;
      load_rd    = 1'b0;
      next_state = IDLE;
    end
  end

  always_ff @(posedge Clock_108M) begin
    if (Reset) begin
      cmd_sr     <= '0;
      bit_cnt    <= '0;
      oe_cnt     <= '0;
      rd_sr      <= '0;
      SPI_MISO   <= 1'b0;
      SPI_Out_EN <= 1'b1;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_wr     <= 1'b0;
      reg_rd     <= 1'b0;
    end else if (frame_end) begin
      bit_cnt    <= '0;
      oe_cnt     <= '0;
      rd_sr      <= '0;
      SPI_MISO   <= 1'b0;
      SPI_Out_EN <= 1'b1;
      reg_wr     <= 1'b0;
      reg_rd     <= 1'b0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      if (bit_rise && bit_cnt != BIT_CNT_MAX) bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      if (shift_en) cmd_sr <= {cmd_sr[CMD_LEN-3:0], mosi_lvl};
      if (last_rise) begin
        reg_addr <= cmd_word[ADDR_MSB:ADDR_LSB];
        if (cmd_word[RW_BIT]) begin
          reg_rd <= 1'b1;
          oe_cnt <= OE_W'(1);
        end else begin
          reg_wr    <= 1'b1;
          reg_wdata <= cmd_word[DATA_MSB:DATA_LSB];
        end
      end else if (oe_cnt != '0 && oe_cnt != OE_LAST) begin
        oe_cnt <= oe_cnt + OE_W'(1);
      end
      if (oe_cnt == OE_LAST) SPI_Out_EN <= 1'b0;
      // Zeros shift in behind the data, so MISO idles low after DATA_W bits.
      if (load_rd) begin
        rd_sr <= reg_rdata;
      end else if (state == DRIVE && clk_fall) begin
        SPI_MISO <= rd_sr[DATA_W-1];
        rd_sr    <= {rd_sr[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_access_ctrl.sv
// Directed self-checking bench for spi_reg_access_ctrl: write/read frames,
// abort, simultaneous SYNC/CLK edge, overlong read, mid-frame reset, back-to-back.
module tb_spi_reg_access_ctrl;

  localparam int HALF = 6;

  logic       Clock_108M = 1'b0;
  logic       Reset = 1'b1;
  logic       SPI_SYNC = 1'b0;
  logic       SPI_CLK = 1'b0;
  logic       SPI_MOSI = 1'b0;
  logic       SPI_MISO;
  logic       SPI_Out_EN;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata = 8'h00;

  int total = 0;
  int bad = 0;

  int cyc = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int oe_low_cnt = 0;
  int rd_cyc = 0;
  int oe_fall_cyc = 0;
  int cap_addr = 0;
  int cap_wdata = 0;
  logic oe_prev = 1'b1;
  logic rd_prev = 1'b0;
  logic [7:0] rd_value = 8'h00;
  logic miso_bits [0:63];

  int wr0, rd0, oe0;

  spi_reg_access_ctrl dut (
    .Clock_108M(Clock_108M), .Reset(Reset),
    .SPI_SYNC(SPI_SYNC), .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI),
    .SPI_MISO(SPI_MISO), .SPI_Out_EN(SPI_Out_EN),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdata(reg_rdata)
  );

  always #5 Clock_108M = ~Clock_108M;

  // Register-file model: returns rd_value exactly one cycle after reg_rd.
  always @(negedge Clock_108M) begin
    cyc++;
    reg_rdata = rd_prev ? rd_value : 8'h00;
    rd_prev = reg_rd;
    if (reg_wr) begin
      wr_cnt++;
      cap_addr = int'(reg_addr);
      cap_wdata = int'(reg_wdata);
    end
    if (reg_rd) begin
      rd_cnt++;
      cap_addr = int'(reg_addr);
      rd_cyc = cyc;
    end
    if (!SPI_Out_EN) begin
      oe_low_cnt++;
      if (oe_prev) oe_fall_cyc = cyc;
    end
    oe_prev = SPI_Out_EN;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge Clock_108M);
  endtask

  task automatic applyStimulus(input logic [15:0] word, input int rises, input bit simul);
    if (!simul) SPI_SYNC = 1'b1;
    for (int j = 0; j < rises; j++) begin
      SPI_MOSI = (j < 16) ? word[15-j] : 1'b0;
      if (simul && j == 0) SPI_SYNC = 1'b1;
      else waitCycles(HALF);
      if (j < 64) miso_bits[j] = SPI_MISO;
      SPI_CLK = 1'b1;
      waitCycles(HALF);
      SPI_CLK = 1'b0;
    end
  endtask

  task automatic endFrame(input int low_cycles);
    waitCycles(HALF);
    SPI_SYNC = 1'b0;
    SPI_MOSI = 1'b0;
    waitCycles(low_cycles);
  endtask

  function automatic int misoByte(input int first);
    logic [7:0] v;
    v = 8'h00;
    for (int k = 0; k < 8; k++) v = {v[6:0], miso_bits[first+k]};
    return int'(v);
  endfunction

  function automatic int misoTailOr(input int first, input int last);
    logic acc;
    acc = 1'b0;
    for (int k = first; k <= last; k++) acc = acc | miso_bits[k];
    return int'(acc);
  endfunction

  initial begin
    waitCycles(4);
    Reset = 1'b0;
    waitCycles(1);
    checkOutput("reset_oe", int'(SPI_Out_EN), 1);
    checkOutput("reset_miso", int'(SPI_MISO), 0);
    checkOutput("reset_wr", int'(reg_wr), 0);
    checkOutput("reset_rd", int'(reg_rd), 0);
    checkOutput("reset_addr", int'(reg_addr), 0);
    checkOutput("reset_wdata", int'(reg_wdata), 0);
    waitCycles(4);

    $display("[TB] write 0x0A55");
    wr0 = wr_cnt; rd0 = rd_cnt; oe0 = oe_low_cnt;
    applyStimulus(16'h0A55, 16, 1'b0);
    endFrame(20);
    checkOutput("wr_count", wr_cnt - wr0, 1);
    checkOutput("wr_no_rd", rd_cnt - rd0, 0);
    checkOutput("wr_addr", cap_addr, 'h0A);
    checkOutput("wr_data", cap_wdata, 'h55);
    checkOutput("wr_oe_high", oe_low_cnt - oe0, 0);

    $display("[TB] read 0x8300 data 0xC3");
    rd_value = 8'hC3;
    wr0 = wr_cnt; rd0 = rd_cnt;
    applyStimulus(16'h8300, 24, 1'b0);
    checkOutput("rd_oe_low", int'(SPI_Out_EN), 0);
    endFrame(20);
    checkOutput("rd_count", rd_cnt - rd0, 1);
    checkOutput("rd_no_wr", wr_cnt - wr0, 0);
    checkOutput("rd_addr", cap_addr, 'h03);
    checkOutput("rd_oe_delay", oe_fall_cyc - rd_cyc, 26);
    checkOutput("rd_miso", misoByte(16), 'hC3);
    checkOutput("rd_end_oe", int'(SPI_Out_EN), 1);
    checkOutput("rd_end_miso", int'(SPI_MISO), 0);

    $display("[TB] abort after 10 rises");
    wr0 = wr_cnt; rd0 = rd_cnt; oe0 = oe_low_cnt;
    applyStimulus(16'h8A55, 10, 1'b0);
    endFrame(20);
    checkOutput("abort_wr", wr_cnt - wr0, 0);
    checkOutput("abort_rd", rd_cnt - rd0, 0);
    checkOutput("abort_oe", oe_low_cnt - oe0, 0);
    applyStimulus(16'h1234, 16, 1'b0);
    endFrame(20);
    checkOutput("post_abort_wr", wr_cnt - wr0, 1);
    checkOutput("post_abort_addr", cap_addr, 'h12);
    checkOutput("post_abort_data", cap_wdata, 'h34);

    $display("[TB] SYNC and CLK rise together");
    wr0 = wr_cnt;
    applyStimulus(16'h7E81, 16, 1'b1);
    endFrame(20);
    checkOutput("simul_wr", wr_cnt - wr0, 1);
    checkOutput("simul_addr", cap_addr, 'h7E);
    checkOutput("simul_data", cap_wdata, 'h81);

    $display("[TB] read 0xFF00 with 40 rises");
    rd_value = 8'h5A;
    wr0 = wr_cnt; rd0 = rd_cnt;
    applyStimulus(16'hFF00, 40, 1'b0);
    checkOutput("long_oe_low", int'(SPI_Out_EN), 0);
    endFrame(20);
    checkOutput("long_rd_count", rd_cnt - rd0, 1);
    checkOutput("long_addr", cap_addr, 'h7F);
    checkOutput("long_miso", misoByte(16), 'h5A);
    checkOutput("long_tail", misoTailOr(24, 39), 0);
    checkOutput("long_end_oe", int'(SPI_Out_EN), 1);

    $display("[TB] reset during read drive");
    rd_value = 8'hFF;
    applyStimulus(16'h8300, 20, 1'b0);
    checkOutput("mid_oe_low", int'(SPI_Out_EN), 0);
    Reset = 1'b1;
    waitCycles(1);
    Reset = 1'b0;
    checkOutput("mid_reset_oe", int'(SPI_Out_EN), 1);
    checkOutput("mid_reset_miso", int'(SPI_MISO), 0);
    wr0 = wr_cnt; rd0 = rd_cnt; oe0 = oe_low_cnt;
    applyStimulus(16'hFFFF, 16, 1'b0);
    endFrame(20);
    checkOutput("mid_no_rd", rd_cnt - rd0, 0);
    checkOutput("mid_no_wr", wr_cnt - wr0, 0);
    checkOutput("mid_oe_stays", oe_low_cnt - oe0, 0);

    $display("[TB] back-to-back read then write");
    rd_value = 8'h3C;
    wr0 = wr_cnt; rd0 = rd_cnt;
    applyStimulus(16'h8600, 24, 1'b0);
    endFrame(2 * HALF);
    checkOutput("b2b_gap_oe", int'(SPI_Out_EN), 1);
    oe0 = oe_low_cnt;
    applyStimulus(16'h0511, 16, 1'b0);
    endFrame(20);
    checkOutput("b2b_rd", rd_cnt - rd0, 1);
    checkOutput("b2b_wr", wr_cnt - wr0, 1);
    checkOutput("b2b_miso", misoByte(16), 'h3C);
    checkOutput("b2b_wr_addr", cap_addr, 'h05);
    checkOutput("b2b_wr_data", cap_wdata, 'h11);
    checkOutput("b2b_wr_oe", oe_low_cnt - oe0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
